perceptron_trainer: RTL
=======================

# perceptron_trainer

Online training controller sitting directly upstream of the two-input perceptron neuron. It holds the neuron's weight and bias registers, drives one training sample at a time into the neuron, and waits out the neuron's two-stage pipeline. It then compares the neuron's thresholded output with the sample's target and applies the perceptron learning rule with saturating unsigned arithmetic. It also tracks per-epoch errors and raises a sticky convergence flag.

## Interface
- `LATENCY`, 2: cycles from applying inputs/weights to a valid neuron output.
- `EPOCH_LEN`, 4: samples per epoch (1..255).
- `LR_SHIFT`, 2: learning rate as a right shift of the input (delta = x >> LR_SHIFT).
- `BIAS_STEP`, 1: bias increment/decrement per error.
- `W_INIT`, 8'd0: reset value of weight1, weight2 and bias.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: training sample valid.
- `s_ready` out 1: trainer can accept a sample.
- `s_x1`, `s_x2` in 8: sample inputs, unsigned.
- `s_target` in 1: desired neuron output.
- `neuron_out` in 16: neuron output word; only bit 0 is used.
- `input1`, `input2`, `weight1`, `weight2`, `bias` out 8 each: registered drives to the neuron.
- `upd_done` out 1: one-cycle pulse when a sample's evaluation and update complete.
- `upd_error` out 1: valid with `upd_done`; 1 means the prediction was wrong.
- `epoch_errors` out 8: error count of the last completed epoch.
- `converged` out 1: sticky; set at the end of an error-free epoch.

## Operation
- States:
  - IDLE: `s_ready`=1. On `s_valid`&&`s_ready`, register x1, x2 and target, drive `input1`/`input2`, load wait counter with LATENCY, and go to WAIT.
  - WAIT: decrement the counter. When it reaches 1, go to EVAL.
  - EVAL: y = `neuron_out[0]`; err = y != target. Go to UPDATE.
  - UPDATE: apply the rule, pulse `upd_done`, update epoch counters, and return to IDLE.
- Learning rule, applied only when err=1 and `converged`=0:
  - If target=1: w_i = sat255(w_i + (x_i >> LR_SHIFT)) and bias = sat255(bias + BIAS_STEP).
  - If target=0: w_i = sat0(w_i - (x_i >> LR_SHIFT)) and bias = sat0(bias - BIAS_STEP).
  - Compute with 9-bit intermediates and clamp to 0..255.
  - When err=0, or once converged, weights and bias are unchanged.
- Epoch accounting:
  - The sample counter increments on every UPDATE; the error counter increments on err.
  - On the UPDATE that completes sample EPOCH_LEN: copy the error count (with this sample's err included) to `epoch_errors` and clear both counters.
  - If that count is 0, set `converged`.
  - The error counter saturates at 255.
- `converged` clears only on reset. Samples are still accepted and evaluated after convergence; only the weight updates stop.
- `input1`/`input2` hold the last sample's values until the next accept.

## Timing
- Reset values (asynchronous assert, synchronous release on the next edge):
  - State IDLE, `s_ready`=1.
  - `input1`/`input2`=0; `weight1`/`weight2`/`bias`=W_INIT.
  - `upd_done`=0, `upd_error`=0, `epoch_errors`=0, `converged`=0.
  - All counters 0.
- Accept at edge 0, which drives inputs. The neuron's sum register updates at edge 1 and `neuron_out` at edge 2. EVAL samples `neuron_out` in the cycle after edge LATENCY.
- `upd_done` is high in the cycle after the UPDATE edge. Accept-to-`upd_done` is LATENCY+2 cycles, so throughput is one sample per LATENCY+3 cycles.
- `s_ready` is low from the accept edge until state returns to IDLE. A sample presented while `s_ready`=0 is not consumed and must be held by the source.
- Weights change only at the UPDATE edge, so they are stable throughout WAIT/EVAL.
- Reset mid-sample abandons the sample: no update, no count, no `upd_done`.

## Structure
- A shared package `perceptron_pkg` holds:
  - the state enum (IDLE, WAIT, EVAL, UPDATE);
  - the `sat_add8`/`sat_sub8` functions;
  - the DATA_W=8 and OUT_W=16 constants, also used by the neuron.
- One sub-module, `sat_step8`: takes a value, a delta and a direction, and returns the clamped 8-bit result. It is instantiated three times (weight1, weight2, bias).
- The FSM and counters stay in the top module.

## Test plan
- Reset with W_INIT=0, then sample x=(8,4), target=1. All-zero weights give neuron_out=0, so err=1. Expect weight1=2, weight2=1, bias=1, and `upd_done`/`upd_error` high 4 cycles after accept.
- weight1=254 preloaded via repeated errors, then x1=255, target=1, y=0. Expect weight1 clamped to 255, no wrap. A matching target=0 underflow case with weight 1 and x=255 expects 0.
- Correct prediction (y=1, target=1): `upd_done`=1, `upd_error`=0, all weights unchanged.
- EPOCH_LEN=4 with four consecutive correct samples: `epoch_errors`=0 and `converged`=1 after the 4th `upd_done`. A subsequent wrong sample leaves the weights unchanged.
- Hold `s_valid` high continuously: exactly one accept per 5 cycles, with `s_ready` low for the 4 cycles in between.
- Assert reset_n=0 during WAIT: outputs return to reset values immediately, no `upd_done` appears, and the counters read 0 afterwards.

Source files
------------

// File: rtl/perceptron_pkg.sv
// ---------------------------------------------------------------------------
// perceptron_pkg
// Shared definitions for the perceptron neuron and its training controller.
//   DATA_W    : width of inputs, weights and bias
//   OUT_W     : width of the neuron output word
//   state_t   : training controller states
//   sat_add8  : unsigned add that clamps at 255
//   sat_sub8  : unsigned subtract that clamps at 0
// ---------------------------------------------------------------------------
package perceptron_pkg;

    localparam int DATA_W = 8;
    localparam int OUT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        EVAL,
        UPDATE
    } state_t;

    // The ninth bit of the sum is the carry out, which means the true result
    // no longer fits in eight bits.
    function automatic logic [DATA_W-1:0] sat_add8(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
    endfunction

    // The ninth bit of the difference is the borrow, meaning b exceeded a.
    function automatic logic [DATA_W-1:0] sat_sub8(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sat_step8.sv
// ---------------------------------------------------------------------------
// sat_step8
// One saturating learning step: moves a value up or down by a delta and
// clamps the result to 0..255.
//   i_value  : current weight or bias
//   i_delta  : step size
//   i_up     : 1 = add the delta, 0 = subtract it
//   o_result : clamped result
// ---------------------------------------------------------------------------
module sat_step8
    import perceptron_pkg::*;
(
    input  logic [DATA_W-1:0] i_value,
    input  logic [DATA_W-1:0] i_delta,
    input  logic              i_up,
    output logic [DATA_W-1:0] o_result
);

    assign o_result = i_up ? sat_add8(i_value, i_delta)
                           : sat_sub8(i_value, i_delta);

endmodule

// File: rtl/perceptron_trainer.sv
// ---------------------------------------------------------------------------
// perceptron_trainer
// Online training controller for the two-input perceptron neuron. Accepts
// one sample at a time, waits out the neuron pipeline, compares the neuron's
// decision with the target and applies the saturating perceptron rule.
// Tracks per-epoch error counts and raises a sticky convergence flag.
//   clk, reset_n            : clock, asynchronous active-low reset
//   s_valid/s_ready         : sample handshake
//   s_x1, s_x2, s_target    : sample inputs and desired output
//   neuron_out              : neuron output word (bit 0 is the decision)
//   input1/2, weight1/2,
//   bias                    : registered drives to the neuron
//   upd_done, upd_error     : per-sample completion pulse and error flag
//   epoch_errors            : error count of the last completed epoch
//   converged               : sticky, set after an error-free epoch
// ---------------------------------------------------------------------------
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned        LATENCY   = 2,
    parameter int unsigned        EPOCH_LEN = 4,
    parameter int unsigned        LR_SHIFT  = 2,
    parameter logic [DATA_W-1:0]  BIAS_STEP = 8'd1,
    parameter logic [DATA_W-1:0]  W_INIT    = 8'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_x1,
    input  logic [DATA_W-1:0] s_x2,
    input  logic              s_target,
    input  logic [OUT_W-1:0]  neuron_out,
    output logic [DATA_W-1:0] input1,
    output logic [DATA_W-1:0] input2,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] bias,
    output logic              upd_done,
    output logic              upd_error,
    output logic [7:0]        epoch_errors,
    output logic              converged
);

    localparam logic [7:0] LAT_LOAD   = 8'(LATENCY);
    localparam logic [7:0] EPOCH_LAST = 8'(EPOCH_LEN - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic              w_accept;

    logic [DATA_W-1:0] r_input1;
    logic [DATA_W-1:0] r_input2;
    logic              r_target;
    logic [7:0]        r_waitCnt;
    logic              r_err;
    logic [DATA_W-1:0] r_weight1;
    logic [DATA_W-1:0] r_weight2;
    logic [DATA_W-1:0] r_bias;
    logic              r_updDone;
    logic              r_updError;
    logic [7:0]        r_sampleCnt;
    logic [7:0]        r_errCnt;
    logic [7:0]        r_epochErrors;
    logic              r_converged;

    logic [DATA_W-1:0] w_newWeight1;
    logic [DATA_W-1:0] w_newWeight2;
    logic [DATA_W-1:0] w_newBias;
    logic [7:0]        w_errCntNext;

    // Only the decision bit of the neuron word matters here.
    logic              w_unusedNeuronHi;
    assign w_unusedNeuronHi = |neuron_out[OUT_W-1:1];

    // Candidate updated values; the direction of every step follows the target.
    sat_step8 u_stepW1 (
        .i_value (r_weight1),
        .i_delta (r_input1 >> LR_SHIFT),
        .i_up    (r_target),
        .o_result(w_newWeight1)
    );

    sat_step8 u_stepW2 (
        .i_value (r_weight2),
        .i_delta (r_input2 >> LR_SHIFT),
        .i_up    (r_target),
        .o_result(w_newWeight2)
    );

    sat_step8 u_stepBias (
        .i_value (r_bias),
        .i_delta (BIAS_STEP),
        .i_up    (r_target),
        .o_result(w_newBias)
    );

    // Error count including the sample being retired, held at 255.
    assign w_errCntNext = (r_err && (r_errCnt != 8'hFF)) ? r_errCnt + 8'd1 : r_errCnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // WAIT exits when the counter shows 1, so EVAL lands in the cycle after
    // the neuron output register has captured this sample's result.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        s_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (r_waitCnt <= 8'd1) begin
                    w_nextState = EVAL;
                end
            end
            EVAL:    w_nextState = UPDATE;
            UPDATE:  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_input1      <= '0;
            r_input2      <= '0;
            r_target      <= 1'b0;
            r_waitCnt     <= '0;
            r_err         <= 1'b0;
            r_weight1     <= W_INIT;
            r_weight2     <= W_INIT;
            r_bias        <= W_INIT;
            r_updDone     <= 1'b0;
            r_updError    <= 1'b0;
            r_sampleCnt   <= '0;
            r_errCnt      <= '0;
            r_epochErrors <= '0;
            r_converged   <= 1'b0;
        end else begin
            r_updDone  <= 1'b0;
            r_updError <= 1'b0;

            if (w_accept) begin
                r_input1  <= s_x1;
                r_input2  <= s_x2;
                r_target  <= s_target;
                r_waitCnt <= LAT_LOAD;
            end

            if (r_state == WAIT && r_waitCnt != 8'd0) begin
                r_waitCnt <= r_waitCnt - 8'd1;
            end

            if (r_state == EVAL) begin
                r_err <= (neuron_out[0] != r_target);
            end

            // Weights move only here, so they stay stable while the neuron
            // is evaluating the sample.
            if (r_state == UPDATE) begin
                r_updDone  <= 1'b1;
                r_updError <= r_err;
                if (r_err && !r_converged) begin
                    r_weight1 <= w_newWeight1;
                    r_weight2 <= w_newWeight2;
                    r_bias    <= w_newBias;
                end
                if (r_sampleCnt >= EPOCH_LAST) begin
                    r_epochErrors <= w_errCntNext;
                    r_sampleCnt   <= '0;
                    r_errCnt      <= '0;
                    if (w_errCntNext == 8'd0) begin
                        r_converged <= 1'b1;
                    end
                end else begin
                    r_sampleCnt <= r_sampleCnt + 8'd1;
                    r_errCnt    <= w_errCntNext;
                end
            end
        end
    end

    assign input1       = r_input1;
    assign input2       = r_input2;
    assign weight1      = r_weight1;
    assign weight2      = r_weight2;
    assign bias         = r_bias;
    assign upd_done     = r_updDone;
    assign upd_error    = r_updError;
    assign epoch_errors = r_epochErrors;
    assign converged    = r_converged;

endmodule
